// File: rtl/gif_pkg.sv
// Shared types and constants for the GIF line prefetcher.
package gif_pkg;
  localparam int SRAM_ADDR_W = 20;
  localparam int PIX_W       = 8;
  localparam logic [SRAM_ADDR_W-1:0] BASE_ADDR_DEF = 20'h19450;

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, CAPT} fetch_state_t;
endpackage

// File: rtl/gif_line_buffer.sv
// Two-bank pixel line buffer: writes one SRAM word (two pixels) per cycle and
// has a registered single-byte read. Even and odd pixels live in separate arrays.
module gif_line_buffer
  import gif_pkg::*;
#(
  parameter int MAX_WIDTH = 640,
  localparam int WORDS = (MAX_WIDTH + 1) / 2,
  localparam int AW    = $clog2(WORDS)
) (
  input  logic             Clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [AW-1:0]    wr_word,
  input  logic [15:0]      wr_data,
  input  logic             rd_bank,
  input  logic [9:0]       rd_x,
  output logic [PIX_W-1:0] rd_data
);
  logic [PIX_W-1:0] mem_even [2**(AW+1)];
  logic [PIX_W-1:0] mem_odd  [2**(AW+1)];
  logic [PIX_W-1:0] even_q, odd_q;
  logic             sel_odd_q;

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem_even[{wr_bank, wr_word}] <= wr_data[15:8];
      mem_odd[{wr_bank, wr_word}]  <= wr_data[7:0];
    end
    even_q    <= mem_even[{rd_bank, rd_x[AW:1]}];
    odd_q     <= mem_odd[{rd_bank, rd_x[AW:1]}];
    sel_odd_q <= rd_x[0];
  end

  assign rd_data = sel_odd_q ? odd_q : even_q;
endmodule

// File: rtl/gif_line_prefetch.sv
// Streams GIF palette indices from SRAM one scanline ahead of the beam and
// sequences frames. Define SRAM_WAIT_EN to add a WAIT state per word for slow SRAM.
module gif_line_prefetch
  import gif_pkg::*;
#(
  parameter logic [SRAM_ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int MAX_WIDTH = 640,
  parameter int V_LAST    = 524
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic [15:0]            width,
  input  logic [15:0]            height,
  input  logic [8:0]             totalFrameCount,
  input  logic [7:0]             frame_delay,
  input  logic                   HARDWARE_EN,
  input  logic [15:0]            sram_dq,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n,
  output logic [PIX_W-1:0]       pix_index,
  output logic                   pix_valid,
  output logic [8:0]             cur_frame,
  output logic                   underrun,
  output fetch_state_t           fetch_state
);
  localparam int WORDS = (MAX_WIDTH + 1) / 2;
  localparam int AW    = $clog2(WORDS);

  fetch_state_t           state, state_nx;
  logic [9:0]             draw_y_q;
  logic [15:0]            width_c, wpl;
  logic [SRAM_ADDR_W-1:0] frame_words, base, next_base, line_addr;
  logic [AW-1:0]          word_idx;
  logic [7:0]             delay_cnt;
  logic [8:0]             dly_max;
  logic                   primed, fw_stale;
  logic                   disp_bank, fetch_bank;
  logic [1:0]             full;
  logic                   line_ev, ev_vlast, ev_row, row_fetch, fetch_start;
  logic                   last_word, capt_we, advance, pix_ok, valid_q;
  logic [PIX_W-1:0]       rd_data;

  assign width_c   = (width > 16'(MAX_WIDTH)) ? 16'(MAX_WIDTH) : width;
  assign wpl       = (width_c + 16'd1) >> 1;
  assign line_ev   = HARDWARE_EN && (DrawY != draw_y_q);
  assign ev_vlast  = line_ev && (DrawY == 10'(V_LAST));
  assign ev_row    = line_ev && ({6'd0, DrawY} < height);
  assign row_fetch = ev_row && (({6'd0, DrawY} + 16'd1) < height);
  assign fetch_start = ev_vlast || row_fetch;
  assign last_word = ({{(16-AW){1'b0}}, word_idx} == (wpl - 16'd1));
  assign capt_we   = HARDWARE_EN && (state == CAPT) && !line_ev;

  // The first V_LAST after reset loads frame 0 itself: nothing has been shown yet.
  assign dly_max   = (frame_delay == 8'd0) ? 9'd1 : {1'b0, frame_delay};
  assign advance   = ev_vlast && primed && (({1'b0, delay_cnt} + 9'd1) >= dly_max);
  assign next_base = !advance ? base :
                     (cur_frame == totalFrameCount) ? BASE_ADDR : base + frame_words;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!HARDWARE_EN)     state_nx = IDLE;
    else if (fetch_start) state_nx = ADDR;
    else if (line_ev)     state_nx = IDLE;
    else begin
      case (state)
        ADDR: begin
`ifdef SRAM_WAIT_EN
          state_nx = WAIT;
`else
          state_nx = CAPT;
`endif
        end
        WAIT:    state_nx = CAPT;
        CAPT:    state_nx = last_word ? IDLE : ADDR;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    sram_addr   = '0;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_ub_n   = 1'b1;
    sram_lb_n   = 1'b1;
    fetch_state = state;
    if (state != IDLE) begin
      sram_addr = line_addr + SRAM_ADDR_W'(word_idx);
      sram_ce_n = 1'b0;
      sram_oe_n = 1'b0;
      sram_ub_n = 1'b0;
      sram_lb_n = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      draw_y_q    <= '0;
      frame_words <= '0;
      fw_stale    <= 1'b1;
      base        <= BASE_ADDR;
      line_addr   <= BASE_ADDR;
      word_idx    <= '0;
      delay_cnt   <= '0;
      primed      <= 1'b0;
      cur_frame   <= '0;
      underrun    <= 1'b0;
      disp_bank   <= 1'b0;
      fetch_bank  <= 1'b1;
      full        <= 2'b00;
      valid_q     <= 1'b0;
    end else begin
      draw_y_q <= DrawY;
      valid_q  <= pix_ok;
      if (!HARDWARE_EN) fw_stale <= 1'b1;
      else if (fw_stale || (line_ev && DrawY == 10'd0)) begin
        frame_words <= SRAM_ADDR_W'({16'd0, wpl} * {16'd0, height});
        fw_stale    <= 1'b0;
      end
      if (ev_vlast) begin
        primed <= 1'b1;
        base   <= next_base;
        if (primed) begin
          if (advance) begin
            delay_cnt <= '0;
            cur_frame <= (cur_frame == totalFrameCount) ? 9'd0 : cur_frame + 9'd1;
          end else begin
            delay_cnt <= delay_cnt + 8'd1;
          end
        end
      end
      // A new line while a fetch is in flight kills that fetch; its buffer stays empty.
      if (line_ev && state != IDLE) begin
        underrun         <= 1'b1;
        full[fetch_bank] <= 1'b0;
      end
      if (ev_row) disp_bank <= ~disp_bank;
      if (fetch_start) begin
        fetch_bank <= ev_vlast ? ~disp_bank : disp_bank;
        full[ev_vlast ? ~disp_bank : disp_bank] <= 1'b0;
        line_addr  <= ev_vlast ? next_base : line_addr + {4'd0, wpl};
        word_idx   <= '0;
      end else if (capt_we) begin
        if (last_word) full[fetch_bank] <= 1'b1;
        else           word_idx <= word_idx + 1'b1;
      end
    end
  end

  assign pix_ok = HARDWARE_EN && ({6'd0, DrawX} < width_c) &&
                  ({6'd0, DrawY} < height) && full[disp_bank];

  gif_line_buffer #(.MAX_WIDTH(MAX_WIDTH)) u_buf (
    .Clk     (Clk),
    .wr_en   (capt_we),
    .wr_bank (fetch_bank),
    .wr_word (word_idx),
    .wr_data (sram_dq),
    .rd_bank (disp_bank),
    .rd_x    (DrawX),
    .rd_data (rd_data)
  );

  assign pix_valid = valid_q;
  assign pix_index = valid_q ? rd_data : '0;
endmodule
